// File: rtl/pixel_norm_sequencer_if.sv
// Destination stream bundle: valid/ready handshake carrying a
// raster address and a 16-bit normalized pixel (show-ahead head).
interface pixel_norm_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              dst_valid;
  logic              dst_ready;
  logic [ADDR_W-1:0] dst_addr;
  logic [15:0]       dst_data;

  modport master (
    output dst_valid,
    output dst_addr,
    output dst_data,
    input  dst_ready
  );

  modport slave (
    input  dst_valid,
    input  dst_addr,
    input  dst_data,
    output dst_ready
  );
endinterface

// File: rtl/pixel_norm_sequencer.sv
// Frame sequencer: reads IMG_W*IMG_H source pixels, feeds the
// normalizer and streams its results through a credit-limited FIFO.
// Ports: clk, rst (async, active-low), start/busy/done/err control,
// src_* read port, norm_* normalizer link, dst stream (interface).
module pixel_norm_sequencer #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_rd_data,
  output logic [7:0]        norm_pixel_in,
  output logic              norm_valid_in,
  input  logic [15:0]       norm_pixel_out,
  input  logic              norm_valid_out,
  pixel_norm_sequencer_if.master dst
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(N + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] LAST_C  = CW'(N - 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_END = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] in_norm_q, in_norm_d;
  logic          err_q, err_d;
  logic          nvi_q, nvi_d;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [OW-1:0] cnt_q, cnt_d;

  logic accept;
  logic issue;
  logic xfer;
  logic spur;
  logic push;
  logic fifo_nempty;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PTR_END) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_nempty = (cnt_q != '0);
    accept = (state_q == S_IDLE) && start;
    issue  = (state_q == S_RUN)
           && (rd_cnt_q < N_C)
           && (out_q < DEPTH_C);
    xfer   = fifo_nempty && dst.dst_ready;
    // A result with nothing in flight is flagged, never stored.
    spur   = norm_valid_out && (in_norm_q == '0);
    push   = norm_valid_out && !spur;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (issue && rd_cnt_q == LAST_C)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (xfer && wr_cnt_q == LAST_C)
          state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    out_d     = out_q;
    in_norm_d = in_norm_q;
    err_d     = err_q;
    nvi_d     = issue;
    if (accept) begin
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      out_d     = '0;
      in_norm_d = '0;
      err_d     = 1'b0;
    end else begin
      if (issue)
        rd_cnt_d = rd_cnt_q + 1'b1;
      if (xfer)
        wr_cnt_d = wr_cnt_q + 1'b1;
      if (issue && !xfer)
        out_d = out_q + 1'b1;
      else if (!issue && xfer)
        out_d = out_q - 1'b1;
      if (nvi_q && !push)
        in_norm_d = in_norm_q + 1'b1;
      else if (!nvi_q && push)
        in_norm_d = in_norm_q - 1'b1;
    end
    if (spur)
      err_d = 1'b1;
  end

  // Output FIFO; the outstanding limit keeps it from overflowing.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = norm_pixel_out;
      wp_d        = nxt(wp_q);
    end
    if (xfer)
      rp_d = nxt(rp_q);
    if (push && !xfer)
      cnt_d = cnt_q + 1'b1;
    else if (!push && xfer)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      out_q     <= '0;
      in_norm_q <= '0;
      err_q     <= 1'b0;
      nvi_q     <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      out_q     <= out_d;
      in_norm_q <= in_norm_d;
      err_q     <= err_d;
      nvi_q     <= nvi_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    busy          = (state_q == S_RUN)
                 || (state_q == S_DRAIN);
    done          = (state_q == S_FIN);
    err           = err_q;
    src_rd_en     = issue;
    src_addr      = ADDR_W'(rd_cnt_q);
    norm_pixel_in = src_rd_data;
    norm_valid_in = nvi_q;
    dst.dst_valid = fifo_nempty;
    dst.dst_addr  = ADDR_W'(wr_cnt_q);
    dst.dst_data  = fifo_nempty ? mem_q[rp_q] : '0;
  end

endmodule

// File: tb/tb_pixel_norm_sequencer.sv
// Directed bench: 4x4 frames (plain, stalled, restart, reset, error)
// on one instance, a 1x1 frame on a second instance.
module tb_pixel_norm_sequencer;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] nf(input logic [7:0] p);
    return {8'h00, p} * 16'd3 + 16'h0101;
  endfunction

  // ---------------- instance A: 4x4 ----------------
  logic          start = 1'b0;
  logic          busy, done, err;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_rd_data = 8'h00;
  logic [7:0]    norm_pixel_in;
  logic          norm_valid_in;
  logic [15:0]   norm_pixel_out;
  logic          norm_valid_out;
  logic          inj = 1'b0;
  logic          nvo_q;
  logic [15:0]   npo_q;

  pixel_norm_sequencer_if #(.ADDR_W(AW)) dif ();

  pixel_norm_sequencer #(
    .IMG_W(4), .IMG_H(4), .ADDR_W(AW), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err),
    .src_rd_en(src_rd_en),
    .src_addr(src_addr),
    .src_rd_data(src_rd_data),
    .norm_pixel_in(norm_pixel_in),
    .norm_valid_in(norm_valid_in),
    .norm_pixel_out(norm_pixel_out),
    .norm_valid_out(norm_valid_out),
    .dst(dif)
  );

  // Source holds a ramp: pixel i = i*16.
  always @(posedge clk)
    if (src_rd_en) src_rd_data <= {src_addr, 4'h0};

  // Normalizer with latency 1.
  always @(posedge clk or negedge rst)
    if (!rst) begin
      nvo_q <= 1'b0;
      npo_q <= '0;
    end else begin
      nvo_q <= norm_valid_in;
      npo_q <= nf(norm_pixel_in);
    end

  assign norm_valid_out = nvo_q | inj;
  assign norm_pixel_out = inj ? 16'hDEAD : npo_q;

  // Monitor A
  int c0 = 0;
  int rel;
  assign rel = cyc - c0;
  int viol, done_n, done_at;
  int busy_n, busy_first, busy_last, outst;
  logic err1;
  logic [AW-1:0] xa[$];
  logic [15:0]   xd[$];
  logic [AW-1:0] rq[$];

  always @(negedge clk) begin
    if (rel == 0) begin
      viol <= 0; done_n <= 0; done_at <= -1;
      busy_n <= 0; busy_first <= -1;
      busy_last <= -1; outst <= 0;
      xa.delete(); xd.delete(); rq.delete();
    end else if (!rst) begin
      outst <= 0;
    end else begin
      if (src_rd_en) begin
        if (outst == 4) viol <= viol + 1;
        rq.push_back(src_addr);
      end
      if (dif.dst_valid && dif.dst_ready) begin
        xa.push_back(dif.dst_addr);
        xd.push_back(dif.dst_data);
      end
      if (done) begin
        done_n  <= done_n + 1;
        done_at <= rel;
      end
      if (busy) begin
        busy_n <= busy_n + 1;
        if (busy_first < 0) busy_first <= rel;
        busy_last <= rel;
      end
      if (rel == 1) err1 <= err;
      outst <= outst
        + (src_rd_en ? 1 : 0)
        - ((dif.dst_valid && dif.dst_ready) ? 1 : 0);
    end
  end

  // ---------------- instance B: 1x1 ----------------
  logic          start1 = 1'b0;
  logic          busy1, done1, err1b;
  logic          rd1;
  logic [AW-1:0] addr1;
  logic [7:0]    rdat1 = 8'h00;
  logic [7:0]    npi1;
  logic          nvi1;
  logic          nvo1;
  logic [15:0]   npo1;

  pixel_norm_sequencer_if #(.ADDR_W(AW)) dif1 ();

  pixel_norm_sequencer #(
    .IMG_W(1), .IMG_H(1), .ADDR_W(AW), .FIFO_DEPTH(4)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .start(start1),
    .busy(busy1),
    .done(done1),
    .err(err1b),
    .src_rd_en(rd1),
    .src_addr(addr1),
    .src_rd_data(rdat1),
    .norm_pixel_in(npi1),
    .norm_valid_in(nvi1),
    .norm_pixel_out(npo1),
    .norm_valid_out(nvo1),
    .dst(dif1)
  );

  always @(posedge clk)
    if (rd1) rdat1 <= (addr1 == '0) ? 8'hA5 : 8'h00;

  always @(posedge clk or negedge rst)
    if (!rst) begin
      nvo1 <= 1'b0;
      npo1 <= '0;
    end else begin
      nvo1 <= nvi1;
      npo1 <= nf(npi1);
    end

  int c1 = 0;
  int rel1;
  assign rel1 = cyc - c1;
  int done1_n, done1_at;
  logic [AW-1:0] xa1[$];
  logic [15:0]   xd1[$];
  logic [AW-1:0] rq1[$];

  always @(negedge clk) begin
    if (rel1 == 0) begin
      done1_n <= 0; done1_at <= -1;
      xa1.delete(); xd1.delete(); rq1.delete();
    end else if (rst) begin
      if (rd1) rq1.push_back(addr1);
      if (dif1.dst_valid && dif1.dst_ready) begin
        xa1.push_back(dif1.dst_addr);
        xd1.push_back(dif1.dst_data);
      end
      if (done1) begin
        done1_n  <= done1_n + 1;
        done1_at <= rel1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run(
    input int ncyc,
    input int st_lo,
    input int st_hi,
    input int re_at
  );
    @(posedge clk); #1;
    c0 = cyc;
    for (int r = 0; r < ncyc; r++) begin
      start = (r == 0) || (r == re_at);
      dif.dst_ready = (r < st_lo) || (r > st_hi);
      @(posedge clk); #1;
    end
    start = 1'b0;
    dif.dst_ready = 1'b1;
  endtask

  task automatic check_frame(
    input string tag,
    input int    exp_done
  );
    chk({tag, ".done_n"}, done_n, 1);
    chk({tag, ".done_at"}, done_at, exp_done);
    chk({tag, ".busy_first"}, busy_first, 1);
    chk({tag, ".busy_last"}, busy_last, exp_done - 1);
    chk({tag, ".busy_n"}, busy_n, exp_done - 1);
    chk({tag, ".xfers"}, xa.size(), 16);
    chk({tag, ".reads"}, rq.size(), 16);
    chk({tag, ".rd_at_full"}, viol, 0);
    for (int i = 0; i < xa.size(); i++) begin
      logic [7:0] px;
      px = 8'(i * 16);
      chk($sformatf("%s.addr%0d", tag, i), xa[i], i);
      chk($sformatf("%s.data%0d", tag, i), xd[i], nf(px));
    end
    for (int i = 0; i < rq.size(); i++)
      chk($sformatf("%s.rd%0d", tag, i), rq[i], i);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".src_rd_en"}, src_rd_en, 0);
    chk({tag, ".src_addr"}, src_addr, 0);
    chk({tag, ".norm_valid_in"}, norm_valid_in, 0);
    chk({tag, ".dst_valid"}, dif.dst_valid, 0);
    chk({tag, ".dst_addr"}, dif.dst_addr, 0);
    chk({tag, ".dst_data"}, dif.dst_data, 0);
  endtask

  initial begin
    dif.dst_ready  = 1'b1;
    dif1.dst_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Unstalled frame
    run(36, 1000, -1, -1);
    check_frame("base", 20);
    chk("base.err1", err1, 0);

    // dst_ready low for cycles 4..13
    run(36, 4, 13, -1);
    check_frame("stall", 30);

    // start re-pulsed mid-frame
    run(36, 1000, -1, 5);
    check_frame("restart", 20);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    c0 = cyc;
    for (int r = 0; r < 12; r++) begin
      start = (r == 0);
      if (r == 8) begin
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
      end
      if (r == 10) rst = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("midrst.idle_busy", busy, 0);
    chk("midrst.idle_dv", dif.dst_valid, 0);
    run(36, 1000, -1, -1);
    check_frame("post_rst", 20);

    // Spurious normalizer output while idle
    @(posedge clk); #1;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    chk("spur.err", err, 1);
    chk("spur.dst_valid", dif.dst_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("spur.err_sticky", err, 1);
    chk("spur.dst_valid2", dif.dst_valid, 0);
    chk("spur.busy", busy, 0);
    run(36, 1000, -1, -1);
    chk("after_err.err1", err1, 0);
    chk("after_err.err_end", err, 0);
    check_frame("after_err", 20);

    // 1x1 frame on the second instance
    @(posedge clk); #1;
    c1 = cyc;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("one.done_n", done1_n, 1);
    chk("one.done_at", done1_at, 5);
    chk("one.reads", rq1.size(), 1);
    chk("one.xfers", xa1.size(), 1);
    if (rq1.size() > 0)
      chk("one.rd_addr", rq1[0], 0);
    if (xa1.size() > 0) begin
      chk("one.dst_addr", xa1[0], 0);
      chk("one.dst_data", xd1[0], nf(8'hA5));
    end
    chk("one.err", err1b, 0);
    chk("one.busy", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
